imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port start, input, 1 bit: begin a load; sampled only in IDLE, DONE, ERROR.
REQ-004 SHALL have port byteIn, input, 8 bits: serial program byte.
REQ-005 SHALL have port byteValid, input, 1 bit: byteIn valid.
REQ-006 SHALL have port byteReady, output, 1 bit: loader accepts byteIn this cycle.
REQ-007 SHALL have port wrAddress, output, 8 bits: instruction-memory word address.
REQ-008 SHALL have port wrData, output, 32 bits: assembled instruction word.
REQ-009 SHALL have port wren, output, 1 bit: instruction-memory write strobe.
REQ-010 SHALL have port cpuRst, output, 1 bit: holds processor in reset while high.
REQ-011 SHALL have port done, output, 1 bit: load complete.
REQ-012 SHALL have port error, output, 1 bit: checksum mismatch.

Function
REQ-013 SHALL transfer a byte only on a rising edge where byteValid=1 and byteReady=1.
REQ-014 SHALL implement states IDLE, LEN, LOAD, WRITE, CHECK, DONE, ERROR.
REQ-015 SHALL move IDLE/DONE/ERROR -> LEN on start=1; SHALL clear done, error, wrAddress and the byte index.
REQ-016 SHALL treat the LEN byte as word count N, with 0 meaning 256; LEN -> LOAD on transfer.
REQ-017 SHALL assemble LOAD bytes big-endian: 1st byte -> wrData[31:24], 4th byte -> wrData[7:0]; LOAD -> WRITE on the 4th transfer.
REQ-018 SHALL assert wren for exactly one cycle in WRITE, with wrData and wrAddress stable, in the cycle after the 4th byte is accepted.
REQ-019 SHALL deassert byteReady in WRITE, IDLE, DONE, ERROR, and assert it in LEN, LOAD, CHECK.
REQ-020 SHALL increment wrAddress after each WRITE, wrapping 255 -> 0.
REQ-021 SHALL exit WRITE to LOAD if words written < N, otherwise to CHECK (macro defined) or DONE (macro undefined).
REQ-022 SHALL drive cpuRst=1 in every state except DONE, and drive done=1 only in DONE.
REQ-023 SHALL ignore start in LEN, LOAD, WRITE, CHECK.
REQ-024 SHALL ignore byteValid outside states with byteReady=1; no byte is consumed.
REQ-025 SHALL, when the stream stalls (byteValid=0), hold state, partial word and address indefinitely.

Reset
REQ-026 SHALL, on rst=1 at any time including mid-load, force state IDLE, wren=0, wrAddress=0, wrData=0, byteReady=0, done=0, error=0, cpuRst=1, without waiting for clk.
REQ-027 SHALL discard any partial word on reset; no write is issued for it.

Configuration
REQ-028 SHALL compile the checksum feature in only when macro LOADER_CHECKSUM_EN is defined.
REQ-029 SHALL, with LOADER_CHECKSUM_EN defined, keep an 8-bit modulo-256 sum of all LOAD bytes, excluding the LEN byte. In CHECK it SHALL accept one byte: equal to the sum -> DONE; different -> ERROR with error=1 and cpuRst=1.
REQ-030 SHALL, with LOADER_CHECKSUM_EN undefined, contain no CHECK or ERROR logic and tie error to 0.

Verification
REQ-031 SHALL cover: reset, start, bytes 01,20,08,00,05 -> one wren pulse at wrAddress=0, wrData=0x20080005; then done=1, cpuRst=0.
REQ-032 SHALL cover: N=2 with byteValid toggled every other cycle -> writes at addresses 0 and 1 with correct data; byteReady=0 during each WRITE cycle.
REQ-033 SHALL cover: LEN byte 00 (256 words) -> 256 wren pulses at addresses 0..255; wrAddress wraps to 0 afterward.
REQ-034 SHALL cover: rst asserted after 2 bytes of word 3 -> immediate IDLE, no wren, cpuRst=1; a new start then reloads from address 0.
REQ-035 SHALL cover, with LOADER_CHECKSUM_EN: N=1, data 00,00,00,07, checksum 07 -> done=1; checksum 08 -> error=1, done=0, cpuRst=1.
REQ-036 SHALL cover: start pulsed during LOAD -> ignored, load completes normally.

Source files
------------

// File: rtl/imem_loader.sv
// Serial instruction-memory loader: length byte, then big-endian 32-bit words written to IMEM.
// Optional trailing checksum byte is compiled in with `define LOADER_CHECKSUM_EN.
module imem_loader (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  byteIn,
    input  logic        byteValid,
    output logic        byteReady,
    output logic [7:0]  wrAddress,
    output logic [31:0] wrData,
    output logic        wren,
    output logic        cpuRst,
    output logic        done,
    output logic        error,
    output logic [2:0]  state_dbg
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        LOAD  = 3'd2,
        WRITE = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5,
        ERROR = 3'd6
    } state_t;

    // Handshake: a byte moves on a rising edge only when byteValid and byteReady are both high;
    // byteValid is ignored whenever byteReady is low and the stream may stall for any length.
    state_t     state;
    logic [1:0] byte_idx;
    logic [8:0] word_total;
    logic [8:0] word_count;
    logic [8:0] next_count;
    logic       transfer;

    assign transfer   = byteValid && byteReady;
    assign next_count = word_count + 9'd1;
    assign state_dbg  = state;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum;
`else
    assign error = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            byte_idx   <= 2'd0;
            word_total <= 9'd0;
            word_count <= 9'd0;
            wrAddress  <= 8'd0;
            wrData     <= 32'd0;
            wren       <= 1'b0;
            byteReady  <= 1'b0;
            cpuRst     <= 1'b1;
            done       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            error      <= 1'b0;
            sum        <= 8'd0;
`endif
        end else begin
            case (state)
                LEN: begin
                    if (transfer) begin
                        // A length byte of zero stands for a full 256-word image.
                        word_total <= (byteIn == 8'd0) ? 9'd256 : {1'b0, byteIn};
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    if (transfer) begin
                        // Shifting in from the bottom leaves the first byte in [31:24].
                        wrData   <= {wrData[23:0], byteIn};
                        byte_idx <= byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        sum      <= sum + byteIn;
`endif
                        if (byte_idx == 2'd3) begin
                            state     <= WRITE;
                            byteReady <= 1'b0;
                            wren      <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    wren       <= 1'b0;
                    wrAddress  <= wrAddress + 8'd1;
                    word_count <= next_count;
                    if (next_count < word_total) begin
                        state     <= LOAD;
                        byteReady <= 1'b1;
                    end else begin
`ifdef LOADER_CHECKSUM_EN
                        state     <= CHECK;
                        byteReady <= 1'b1;
`else
                        state     <= DONE;
                        done      <= 1'b1;
                        cpuRst    <= 1'b0;
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHECK: begin
                    if (transfer) begin
                        byteReady <= 1'b0;
                        if (byteIn == sum) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            cpuRst <= 1'b0;
                        end else begin
                            state  <= ERROR;
                            error  <= 1'b1;
                        end
                    end
                end
`endif
                // IDLE, DONE and ERROR: wait for start to begin a fresh load.
                default: begin
                    if (start) begin
                        state      <= LEN;
                        byteReady  <= 1'b1;
                        cpuRst     <= 1'b1;
                        done       <= 1'b0;
                        wrAddress  <= 8'd0;
                        byte_idx   <= 2'd0;
                        word_count <= 9'd0;
`ifdef LOADER_CHECKSUM_EN
                        error      <= 1'b0;
                        sum        <= 8'd0;
`endif
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: drives byte streams and checks every IMEM write against an expected queue.
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  byteIn;
    logic        byteValid;
    logic        byteReady;
    logic [7:0]  wrAddress;
    logic [31:0] wrData;
    logic        wren;
    logic        cpuRst;
    logic        done;
    logic        error;
    logic [2:0]  state_dbg;

    imem_loader dut (
        .clk(clk), .rst(rst), .start(start), .byteIn(byteIn), .byteValid(byteValid),
        .byteReady(byteReady), .wrAddress(wrAddress), .wrData(wrData), .wren(wren),
        .cpuRst(cpuRst), .done(done), .error(error), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [39:0] exp_q[$];
    logic [31:0] prog[256];
    logic [7:0]  exp_addr;
    int          wren_count;
    logic        prev_wren;

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: each wren pulse must match the oldest expected {address, word}.
    always @(negedge clk) begin
        if (rst) begin
            prev_wren = 1'b0;
        end else begin
            if (wren) begin
                wren_count++;
                check("ready_in_write", byteReady, 0);
                check("wren_one_cycle", prev_wren, 0);
                check("write_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0)
                    check("write_addr_data", {wrAddress, wrData}, exp_q.pop_front());
            end
            prev_wren = wren;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        int   n;
        logic acc;
        n = 0;
        acc = 1'b0;
        byteIn = b;
        byteValid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = byteReady;
            @(posedge clk);
            #1;
            n++;
        end
        byteValid = 1'b0;
        if (!acc) check("byte_accept_timeout", acc, 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!(done || error) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!(done || error)) check("end_timeout", done, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_load(input int n, input bit gap, input bit mid_start, input bit sum_ok);
        logic [7:0] sum;
        logic [7:0] b;
        bit         exp_err;
        sum = 8'd0;
        exp_err = 1'b0;
        wren_count = 0;
        exp_addr = 8'd0;
        pulse_start();
        send_byte(n[7:0]);
        for (int w = 0; w < n; w++) begin
            for (int k = 0; k < 4; k++) begin
                b = prog[w][31 - 8*k -: 8];
                sum = sum + b;
                if (k == 3) begin
                    exp_q.push_back({exp_addr, prog[w]});
                    exp_addr = exp_addr + 8'd1;
                end
                if (mid_start && w == 0 && k == 1) start = 1'b1;
                send_byte(b);
                start = 1'b0;
                if (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
`ifdef LOADER_CHECKSUM_EN
        exp_err = !sum_ok;
        send_byte(sum_ok ? sum : sum + 8'd1);
`endif
        wait_end();
        check("done", done, !exp_err);
        check("error", error, exp_err);
        check("cpu_rst", cpuRst, exp_err);
        check("ready_after_load", byteReady, 0);
        check("wren_count", wren_count, n);
        check("queue_drained", exp_q.size(), 0);
        check("wr_address_end", wrAddress, exp_addr);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        byteValid = 1'b0;
        byteIn = 8'h00;
        exp_addr = 8'd0;
        wren_count = 0;
        prev_wren = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", state_dbg, 0);
        check("rst_wren", wren, 0);
        check("rst_addr", wrAddress, 0);
        check("rst_data", wrData, 0);
        check("rst_ready", byteReady, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_cpu_rst", cpuRst, 1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single word 0x20080005.
        prog[0] = 32'h20080005;
        run_load(1, 0, 0, 1);

        // byteValid in DONE must be ignored.
        byteIn = 8'hAA;
        byteValid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        byteValid = 1'b0;
        check("done_ignores_valid_ready", byteReady, 0);
        check("done_ignores_valid_done", done, 1);

        // Two words with the stream stalling every other cycle.
        for (int i = 0; i < 2; i++) prog[i] = $urandom;
        run_load(2, 1, 0, 1);

        // Full 256-word image with length byte 00; address wraps back to 0.
        for (int i = 0; i < 256; i++) prog[i] = $urandom;
        run_load(256, 0, 0, 1);
        check("wrap_addr_zero", wrAddress, 0);

        // Start pulsed mid-load is ignored.
        for (int i = 0; i < 3; i++) prog[i] = $urandom;
        run_load(3, 0, 1, 1);

        // Reset after two bytes of the fourth word.
        for (int i = 0; i < 4; i++) prog[i] = $urandom_range(32'hFFFF_FFFF, 0);
        wren_count = 0;
        exp_addr = 8'd0;
        pulse_start();
        send_byte(8'd4);
        for (int w = 0; w < 3; w++) begin
            exp_q.push_back({exp_addr, prog[w]});
            exp_addr = exp_addr + 8'd1;
            send_byte(prog[w][31:24]);
            send_byte(prog[w][23:16]);
            send_byte(prog[w][15:8]);
            send_byte(prog[w][7:0]);
        end
        send_byte(prog[3][31:24]);
        send_byte(prog[3][23:16]);
        #3;
        rst = 1'b1;
        #1;
        check("midrst_state", state_dbg, 0);
        check("midrst_cpu_rst", cpuRst, 1);
        check("midrst_ready", byteReady, 0);
        check("midrst_addr", wrAddress, 0);
        check("midrst_data", wrData, 0);
        check("midrst_wren", wren, 0);
        check("midrst_done", done, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midrst_wren_count", wren_count, 3);
        check("midrst_queue", exp_q.size(), 0);
        for (int i = 0; i < 2; i++) prog[i] = $urandom;
        run_load(2, 0, 0, 1);

`ifdef LOADER_CHECKSUM_EN
        // Checksum 07 accepted, then 08 rejected.
        prog[0] = 32'h00000007;
        run_load(1, 0, 0, 1);
        run_load(1, 0, 0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
